// File: rtl/isp_pkg.sv
// Shared state encoding and object-list entry layout for the ISP tile scheduler.
// Optional perf counters in the top are enabled by defining ISP_TILE_PERF_CNT_EN.
package isp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RGN_RD,
    OL_RD,
    TAG,
    FLUSH,
    NEXT
  } state_t;

  localparam int ENTRY_END      = 31;
  localparam int ENTRY_LINK     = 30;
  localparam int ENTRY_ADDR_MSB = 23;
  localparam int ENTRY_ADDR_LSB = 0;
  localparam int EMPTY_TILE     = 31;

  // A zero tile count is treated as a single tile.
  function automatic logic [5:0] dim_or_one(input logic [5:0] dim);
    return (dim == 6'd0) ? 6'd1 : dim;
  endfunction

endpackage

// File: rtl/isp_tile_walker.sv
// Tile raster walker: holds frame geometry and current tile, computes the
// region-array word address for that tile and flags the last tile.
module isp_tile_walker
  import isp_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic        advance,
  input  logic [23:0] region_base,
  input  logic [5:0]  tiles_w,
  input  logic [5:0]  tiles_h,
  output logic [5:0]  tile_x,
  output logic [5:0]  tile_y,
  output logic [23:0] region_addr,
  output logic        last_tile
);

  logic [23:0] base_reg;
  logic [5:0]  w_reg;
  logic [5:0]  h_reg;
  logic [5:0]  x_reg;
  logic [5:0]  y_reg;
  logic [23:0] tile_index;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_reg <= '0;
      w_reg    <= '0;
      h_reg    <= '0;
      x_reg    <= '0;
      y_reg    <= '0;
    end else if (load) begin
      base_reg <= region_base;
      w_reg    <= dim_or_one(tiles_w);
      h_reg    <= dim_or_one(tiles_h);
      x_reg    <= '0;
      y_reg    <= '0;
    end else if (advance && !last_tile) begin
      if (x_reg == w_reg - 6'd1) begin
        x_reg <= '0;
        y_reg <= y_reg + 6'd1;
      end else begin
        x_reg <= x_reg + 6'd1;
      end
    end
  end

  // Address arithmetic deliberately wraps within the 24-bit VRAM space.
  assign tile_index  = 24'(y_reg) * 24'(w_reg) + 24'(x_reg);
  assign region_addr = base_reg + (tile_index << 2);
  assign last_tile   = (x_reg == w_reg - 6'd1) && (y_reg == h_reg - 6'd1);
  assign tile_x      = x_reg;
  assign tile_y      = y_reg;

endmodule

// File: rtl/isp_tile_scheduler.sv
// Per-tile ISP scheduler: clears the tag buffer, walks each tile's object list
// from VRAM, issues polygon tags and flushes. ISP_TILE_PERF_CNT_EN adds perf counters.
module isp_tile_scheduler
  import isp_pkg::*;
#(
  parameter int LIST_LIMIT = 4096
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [23:0] region_base,
  input  logic [5:0]  tiles_w,
  input  logic [5:0]  tiles_h,
  output logic        busy,
  output logic [5:0]  tile_x,
  output logic [5:0]  tile_y,
  output logic        z_clear,
  output logic        tag_clear,
  input  logic        clear_done,
  output logic        tag_poly,
  output logic [31:0] poly_addr,
  input  logic        tag_done,
  output logic        tile_flush,
  input  logic        flush_done,
  output logic        frame_done,
  output logic        list_overflow,
  output logic        vram_rd,
  output logic [23:0] vram_addr,
  input  logic        vram_valid,
  input  logic [31:0] vram_din
`ifdef ISP_TILE_PERF_CNT_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_polys
`endif
);

  localparam int CW = $clog2(LIST_LIMIT + 1);

  state_t         state_reg, state_next;
  logic [23:0]    ptr_reg, ptr_next;
  logic [23:0]    poly_reg, poly_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           ovf_reg, ovf_next;
  logic           load;
  logic           advance;
  logic           last_tile;
  logic           limit_hit;
  logic [23:0]    region_addr;
  logic           din_unused;

  isp_tile_walker u_walker (
    .clock       (clock),
    .reset_n     (reset_n),
    .load        (load),
    .advance     (advance),
    .region_base (region_base),
    .tiles_w     (tiles_w),
    .tiles_h     (tiles_h),
    .tile_x      (tile_x),
    .tile_y      (tile_y),
    .region_addr (region_addr),
    .last_tile   (last_tile)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      poly_reg  <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      poly_reg  <= poly_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
    end
  end

  // True when the word now arriving is the LIST_LIMIT-th of this tile.
  assign limit_hit = (int'(cnt_reg) + 1) >= LIST_LIMIT;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    poly_next  = poly_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    load       = 1'b0;
    advance    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          ovf_next   = 1'b0;
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        if (clear_done) state_next = RGN_RD;
      end
      RGN_RD: begin
        if (vram_valid) begin
          if (vram_din[EMPTY_TILE]) begin
            state_next = FLUSH;
          end else begin
            ptr_next   = vram_din[ENTRY_ADDR_MSB:ENTRY_ADDR_LSB];
            cnt_next   = '0;
            state_next = OL_RD;
          end
        end
      end
      OL_RD: begin
        if (vram_valid) begin
          cnt_next = cnt_reg + CW'(1);
          if (vram_din[ENTRY_END]) begin
            state_next = FLUSH;
          end else if (limit_hit) begin
            ovf_next   = 1'b1;
            state_next = FLUSH;
          end else if (vram_din[ENTRY_LINK]) begin
            ptr_next = vram_din[ENTRY_ADDR_MSB:ENTRY_ADDR_LSB];
          end else begin
            poly_next  = vram_din[ENTRY_ADDR_MSB:ENTRY_ADDR_LSB];
            ptr_next   = ptr_reg + 24'd4;
            state_next = TAG;
          end
        end
      end
      TAG: begin
        if (tag_done) state_next = OL_RD;
      end
      FLUSH: begin
        if (flush_done) state_next = NEXT;
      end
      NEXT: begin
        if (last_tile) begin
          state_next = IDLE;
        end else begin
          advance    = 1'b1;
          state_next = CLEAR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy          = (state_reg != IDLE);
  assign z_clear       = (state_reg == CLEAR);
  assign tag_clear     = (state_reg == CLEAR);
  assign tag_poly      = (state_reg == TAG);
  assign tile_flush    = (state_reg == FLUSH);
  assign vram_rd       = (state_reg == RGN_RD) || (state_reg == OL_RD);
  assign vram_addr     = (state_reg == RGN_RD) ? region_addr :
                         (state_reg == OL_RD)  ? ptr_reg : 24'd0;
  assign poly_addr     = {8'h00, poly_reg};
  assign frame_done    = (state_reg == NEXT) && last_tile;
  assign list_overflow = ovf_reg;
  assign din_unused    = ^vram_din[29:24];

`ifdef ISP_TILE_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_cycles <= '0;
      perf_polys  <= '0;
    end else if (load) begin
      perf_cycles <= '0;
      perf_polys  <= '0;
    end else begin
      if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
      if (state_reg == TAG && tag_done && perf_polys != '1) perf_polys <= perf_polys + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_isp_tile_scheduler.sv
// Self-checking bench for isp_tile_scheduler: VRAM and tag-buffer responders feed
// a scoreboard of expected clear/tag/flush/frame events built from a frame table.
`timescale 1ns/1ps
module tb_isp_tile_scheduler;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] region_base = '0;
  logic [5:0]  tiles_w = '0;
  logic [5:0]  tiles_h = '0;
  logic        busy;
  logic [5:0]  tile_x, tile_y;
  logic        z_clear, tag_clear, clear_done;
  logic        tag_poly, tag_done;
  logic [31:0] poly_addr;
  logic        tile_flush, flush_done;
  logic        frame_done, list_overflow;
  logic        vram_rd;
  logic [23:0] vram_addr;
  logic        vram_valid = 1'b0;
  logic [31:0] vram_din = '0;
  logic [2:0]  hs_done = '0;
`ifdef ISP_TILE_PERF_CNT_EN
  logic [31:0] perf_cycles, perf_polys;
`endif

  assign clear_done = hs_done[0];
  assign tag_done   = hs_done[1];
  assign flush_done = hs_done[2];

  isp_tile_scheduler #(.LIST_LIMIT(LIMIT)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .region_base  (region_base),
    .tiles_w      (tiles_w),
    .tiles_h      (tiles_h),
    .busy         (busy),
    .tile_x       (tile_x),
    .tile_y       (tile_y),
    .z_clear      (z_clear),
    .tag_clear    (tag_clear),
    .clear_done   (clear_done),
    .tag_poly     (tag_poly),
    .poly_addr    (poly_addr),
    .tag_done     (tag_done),
    .tile_flush   (tile_flush),
    .flush_done   (flush_done),
    .frame_done   (frame_done),
    .list_overflow(list_overflow),
    .vram_rd      (vram_rd),
    .vram_addr    (vram_addr),
    .vram_valid   (vram_valid),
    .vram_din     (vram_din)
`ifdef ISP_TILE_PERF_CNT_EN
    ,
    .perf_cycles  (perf_cycles),
    .perf_polys   (perf_polys)
`endif
  );

  initial forever #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] val;
  } ev_t;

  // kind: 0 single poly/tile, 1 empty, 2 link, 3 zero dims, 4 no END, 5 mixed
  typedef struct {
    logic [5:0]  w;
    logic [5:0]  h;
    logic [23:0] base;
    int          kind;
    int          exp_tiles;
    logic        exp_ovf;
  } vec_t;

  localparam logic [31:0] END_WORD = 32'h8000_0000;

  logic [31:0] mem [logic [23:0]];
  ev_t         exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          frames_seen = 0;
  int          flushes_seen = 0;
  int          vram_delay = 0;
  int          hs_delay = 0;
  vec_t        tbl[7];

  function automatic logic [31:0] mem_rd(input logic [23:0] a);
    return mem.exists(a) ? mem[a] : END_WORD;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic push_ev(input logic [1:0] kind, input logic [31:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic got_event(input logic [1:0] kind, input logic [31:0] val);
    ev_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected event: got kind %0d val %h, want none", kind, val);
    end else begin
      e = exp_q.pop_front();
      check("event kind", 32'(kind), 32'(e.kind));
      check("event value", val, e.val);
      $display("event kind=%0d val=%h", kind, val);
    end
  endtask

  // Single responder for VRAM and the three tag-buffer handshakes.
  initial begin : responder
    int          rd_cnt;
    int          hs_cnt[3];
    logic [23:0] rd_addr0;
    logic [2:0]  reqs;
    rd_cnt   = 0;
    hs_cnt   = '{0, 0, 0};
    rd_addr0 = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        vram_valid = 1'b0;
        hs_done    = '0;
        rd_cnt     = 0;
        hs_cnt     = '{0, 0, 0};
      end else begin
        reqs = {tile_flush, tag_poly, z_clear};
        if (int'(vram_rd) + int'(reqs[0]) + int'(reqs[1]) + int'(reqs[2]) > 1) begin
          miscompares++;
          $display("FAIL exclusive requests: got rd=%b clr=%b tag=%b flush=%b, want at most one",
                   vram_rd, reqs[0], reqs[1], reqs[2]);
        end
        if (vram_valid) begin
          vram_valid = 1'b0;
          rd_cnt     = 0;
        end
        if (vram_rd) begin
          if (rd_cnt == 0) rd_addr0 = vram_addr;
          if (rd_cnt >= vram_delay) begin
            if (rd_cnt > 0) check("vram_addr stable", 32'(vram_addr), 32'(rd_addr0));
            vram_valid = 1'b1;
            vram_din   = mem_rd(vram_addr);
          end else begin
            rd_cnt++;
          end
        end
        for (int k = 0; k < 3; k++) begin
          if (hs_done[k]) begin
            hs_done[k] = 1'b0;
            hs_cnt[k]  = 0;
          end
          if (reqs[k]) begin
            if (hs_cnt[k] >= hs_delay) begin
              hs_done[k] = 1'b1;
              if (k == 0) begin
                check("tag_clear with z_clear", 32'(tag_clear), 32'd1);
                got_event(2'd0, {20'd0, tile_y, tile_x});
              end else if (k == 1) begin
                got_event(2'd1, poly_addr);
              end else begin
                flushes_seen++;
                got_event(2'd2, {20'd0, tile_y, tile_x});
              end
            end else begin
              hs_cnt[k]++;
            end
          end
        end
        if (frame_done) begin
          frames_seen++;
          got_event(2'd3, 32'd0);
        end
      end
    end
  end

  task automatic tile_single(input int idx, input logic [23:0] raddr);
    logic [23:0] la, p;
    la = 24'h010000 + 24'(idx * 16);
    p  = 24'h001000 + 24'(idx * 256);
    mem[raddr] = {8'h00, la};
    mem[la]    = {8'h00, p};
    mem[la + 24'd4] = END_WORD;
    push_ev(2'd1, {8'h00, p});
  endtask

  task automatic build_frame(input vec_t v);
    int ew, eh, idx;
    logic [23:0] raddr, la, t, p;
    exp_q.delete();
    mem.delete();
    ew = (v.w == 0) ? 1 : int'(v.w);
    eh = (v.h == 0) ? 1 : int'(v.h);
    for (int y = 0; y < eh; y++) begin
      for (int x = 0; x < ew; x++) begin
        idx   = y * ew + x;
        raddr = v.base + 24'(4 * idx);
        push_ev(2'd0, 32'({y[5:0], x[5:0]}));
        case (v.kind)
          1: mem[raddr] = END_WORD;
          2: begin
            la = 24'h00A000 + 24'(idx * 16);
            t  = 24'h002000 + 24'(idx * 16);
            p  = 24'h003000 + 24'(idx * 256);
            mem[raddr] = {8'h00, la};
            mem[la]    = {8'h40, t};
            mem[t]     = {8'h00, p};
            mem[t + 24'd4] = END_WORD;
            push_ev(2'd1, {8'h00, p});
          end
          4: begin
            la = 24'h020000 + 24'(idx * 64);
            mem[raddr] = {8'h00, la};
            for (int j = 0; j < 6; j++) mem[la + 24'(4 * j)] = {8'h00, 24'h005000 + 24'(j * 256)};
            for (int j = 0; j < LIMIT - 1; j++) push_ev(2'd1, {8'h00, 24'h005000 + 24'(j * 256)});
          end
          5: begin
            if (idx % 2 == 1) tile_single(idx, raddr);
            else mem[raddr] = END_WORD;
          end
          default: tile_single(idx, raddr);
        endcase
        push_ev(2'd2, 32'({y[5:0], x[5:0]}));
      end
    end
    push_ev(2'd3, 32'd0);
  endtask

  task automatic run_frame(input vec_t v, input bit poke);
    int f0, fl0;
    build_frame(v);
    f0  = frames_seen;
    fl0 = flushes_seen;
    @(negedge clock);
    region_base = v.base;
    tiles_w     = v.w;
    tiles_h     = v.h;
    start       = 1'b1;
    @(negedge clock);
    start       = 1'b0;
    region_base = 24'hABCDEF;
    tiles_w     = 6'd5;
    tiles_h     = 6'd5;
    check("busy after start", 32'(busy), 32'd1);
    for (int c = 0; c < 3000 && frames_seen == f0; c++) begin
      @(negedge clock);
      start = poke && (c == 8);
    end
    start = 1'b0;
    if (frames_seen == f0) begin
      vectors++;
      miscompares++;
      $display("FAIL frame timeout: got no frame_done, want one");
    end
    @(negedge clock);
    check("busy after frame", 32'(busy), 32'd0);
    check("frame_done count", 32'(frames_seen - f0), 32'd1);
    check("tiles flushed", 32'(flushes_seen - fl0), 32'(v.exp_tiles));
    check("list_overflow", 32'(list_overflow), 32'(v.exp_ovf));
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("frame base=%h w=%0d h=%0d kind=%0d done", v.base, v.w, v.h, v.kind);
  endtask

  initial begin : main
    int f0;
    tbl[0] = '{w: 6'd2, h: 6'd1, base: 24'h000100, kind: 0, exp_tiles: 2, exp_ovf: 1'b0};
    tbl[1] = '{w: 6'd1, h: 6'd1, base: 24'h000200, kind: 1, exp_tiles: 1, exp_ovf: 1'b0};
    tbl[2] = '{w: 6'd1, h: 6'd1, base: 24'h000300, kind: 2, exp_tiles: 1, exp_ovf: 1'b0};
    tbl[3] = '{w: 6'd0, h: 6'd0, base: 24'h000400, kind: 3, exp_tiles: 1, exp_ovf: 1'b0};
    tbl[4] = '{w: 6'd1, h: 6'd1, base: 24'h000600, kind: 4, exp_tiles: 1, exp_ovf: 1'b1};
    tbl[5] = '{w: 6'd3, h: 6'd2, base: 24'hFFFFF8, kind: 0, exp_tiles: 6, exp_ovf: 1'b0};
    tbl[6] = '{w: 6'd2, h: 6'd2, base: 24'h000500, kind: 5, exp_tiles: 4, exp_ovf: 1'b0};

    repeat (3) @(negedge clock);
    check("reset busy", 32'(busy), 32'd0);
    check("reset controls", 32'({vram_rd, z_clear, tag_clear, tag_poly, tile_flush, frame_done, list_overflow}), 32'd0);
    check("reset tile", 32'({tile_y, tile_x}), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      vram_delay = i % 3;
      hs_delay   = (i + 1) % 3;
      run_frame(tbl[i], 1'b0);
    end

    // Slow VRAM, immediate tag completion, stray start mid-frame.
    vram_delay = 5;
    hs_delay   = 0;
    run_frame(tbl[2], 1'b1);
    run_frame(tbl[0], 1'b1);

    // Reset while a tag request is outstanding.
    vram_delay = 0;
    hs_delay   = 30;
    build_frame(tbl[0]);
    @(negedge clock);
    region_base = tbl[0].base;
    tiles_w     = tbl[0].w;
    tiles_h     = tbl[0].h;
    start       = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c < 200 && !tag_poly; c++) @(negedge clock);
    check("tag_poly reached", 32'(tag_poly), 32'd1);
    @(negedge clock);
    f0 = frames_seen;
    reset_n = 1'b0;
    #1;
    check("mid-frame reset busy", 32'(busy), 32'd0);
    check("mid-frame reset controls", 32'({vram_rd, z_clear, tag_clear, tag_poly, tile_flush, frame_done, list_overflow}), 32'd0);
    check("mid-frame reset poly_addr", poly_addr, 32'd0);
    check("mid-frame reset tile", 32'({tile_y, tile_x}), 32'd0);
    check("mid-frame reset vram_addr", 32'(vram_addr), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clock);
    reset_n  = 1'b1;
    hs_delay = 0;
    check("no frame_done after reset", 32'(frames_seen - f0), 32'd0);
    run_frame(tbl[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/isp_tile_scheduler.md
ISP_TILE_SCHEDULER -- requirements
Module: isp_tile_scheduler

Interface
REQ-001 Parameter: LIST_LIMIT, 4096, maximum object-list words walked per tile before forced termination.
REQ-002 clock  input  1  system clock; all logic on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse; begins a frame render; ignored while busy.
REQ-005 region_base  input  24  VRAM byte address of region array; word-aligned; sampled on accepted start.
REQ-006 tiles_w, tiles_h  input  6 each  tile counts (1..63); sampled on accepted start; a value of 0 is treated as 1.
REQ-007 busy  output  1  high from accepted start until frame_done.
REQ-008 tile_x, tile_y  output  6 each  current tile coordinates to tag buffer.
REQ-009 z_clear, tag_clear  output  1 each  clear request to tag buffer; held until clear_done.
REQ-010 clear_done  input  1  tag buffer clear complete.
REQ-011 tag_poly  output  1  polygon tag request; held until tag_done; poly_addr stable while high.
REQ-012 poly_addr  output  32  polygon parameter address ({8'h00, entry[23:0]}).
REQ-013 tag_done  input  1  polygon tag complete.
REQ-014 tile_flush  output  1  tile finished, request shading/writeback; held until flush_done.
REQ-015 flush_done  input  1  flush complete.
REQ-016 frame_done  output  1  one-cycle pulse after the last tile flushes.
REQ-017 list_overflow  output  1  sticky; set when LIST_LIMIT is hit; cleared on accepted start.
REQ-018 vram_rd  output  1  read request; held until vram_valid.
REQ-019 vram_addr  output  24  read address; stable while vram_rd.
REQ-020 vram_valid  input  1  read data valid this cycle; completes the request.
REQ-021 vram_din  input  32  read data.

Function
REQ-022 FSM states: IDLE, CLEAR, RGN_RD, OL_RD, TAG, FLUSH, NEXT.
REQ-023 IDLE: on start, latch inputs, tile_x=tile_y=0, clear list_overflow, assert busy, go to CLEAR next cycle.
REQ-024 CLEAR: assert z_clear and tag_clear together; on clear_done, deassert both the same edge and go to RGN_RD.
REQ-025 RGN_RD: read region_base + 4*(tile_y*tiles_w + tile_x), computed in 24 bits with wrap-around; on vram_valid: if bit31 is set (empty tile), go to FLUSH; otherwise the list pointer is bits[23:0] and the next state is OL_RD.
REQ-026 OL_RD: read the word at the list pointer and increment the word count; on vram_valid: bit31 = end of list, go to FLUSH; bit30 = link, pointer = bits[23:0], stay in OL_RD; otherwise poly_addr = bits[23:0], pointer += 4, go to TAG.
REQ-027 TAG: assert tag_poly; on tag_done, go to OL_RD.
REQ-028 Word count reaching LIST_LIMIT before end-of-list: set list_overflow, go to FLUSH.
REQ-029 FLUSH: assert tile_flush; on flush_done, go to NEXT.
REQ-030 NEXT: raster order, x first; after x=tiles_w-1, set x=0 and y+1; after the last tile, pulse frame_done, drop busy, go to IDLE; otherwise go to CLEAR.
REQ-031 Handshake inputs that arrive in a state not waiting on them are ignored; at most one of vram_rd, tag_poly, tile_flush, clear requests is high per cycle.
REQ-032 A done/valid in the first cycle of a request completes it; minimum 1-cycle request.

Reset
REQ-033 Reset forces IDLE, all outputs 0, counters 0, list_overflow 0; reset mid-frame abandons the frame with no frame_done.

Configuration
REQ-034 ISP_TILE_PERF_CNT_EN defined: outputs perf_cycles[31:0] (busy cycles) and perf_polys[31:0] (tag_done count), both zeroed on accepted start and saturating at all-ones.
REQ-035 ISP_TILE_PERF_CNT_EN undefined: those ports and counters are absent; behaviour is otherwise identical.

Structure
REQ-036 Shared package isp_pkg: FSM state enum, list-entry bit positions (END=31, LINK=30, ADDR=23:0), and EMPTY_TILE=31.
REQ-037 One sub-module, isp_tile_walker: holds tile_x/tile_y and the region-address computation and reports last-tile.

Verification
REQ-038 2x1 tiles, each with a list {P0=0x001000, END} -> clear, tag 0x001000, flush per tile; frame_done once; tile order (0,0),(1,0).
REQ-039 Tile region word 0x80000000 -> clear then flush with no tag_poly.
REQ-040 List {0x40002000 link, at 0x002000: 0x003000, END} -> tag_poly at 0x003000 only.
REQ-041 LIST_LIMIT=4 with no END -> 3 tags, list_overflow=1, frame still completes.
REQ-042 vram_valid delayed 5 cycles, tag_done same-cycle -> address stable, no dropped or duplicate request.
REQ-043 reset_n low during TAG -> all outputs 0 next cycle; new start runs a clean frame.
